// File: rtl/simd_result_drain.sv
// Ping-pong capture of the accumulated_mult matrix, streamed one element per cycle over valid/ready.
// Latency: first out_valid CAPTURE_DLY+1 cycles after rollover; outputs hold while stalled; captures drop (sticky overflow) when both banks are full.
module simd_result_drain #(
  parameter int NUM_ELEM    = 16,
  parameter int ACC_WIDTH   = 24,
  parameter int CAPTURE_DLY = 2,
  parameter int IDX_W       = $clog2(NUM_ELEM)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          rollover,
  input  logic [NUM_ELEM*ACC_WIDTH-1:0] acc_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACC_WIDTH-1:0]          out_data,
  output logic [IDX_W-1:0]              out_idx,
  output logic                          out_last,
  output logic                          busy,
  output logic                          overflow,
  input  logic                          clr_ovf
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t               state, state_nxt;
  logic [CAPTURE_DLY-1:0] cap_sr;
  logic                 cap;
  logic [1:0]           bank_full, bank_full_nxt;
  logic                 rd_ptr, rd_ptr_nxt;
  logic                 wr_ptr;
  logic [IDX_W-1:0]     idx, idx_nxt;
  logic                 rel_bank;
  logic                 load_data;
  logic                 wr_free;
  logic                 do_write;
  logic                 do_drop;
  logic [ACC_WIDTH-1:0] mem [2][NUM_ELEM];

  assign cap       = cap_sr[CAPTURE_DLY-1];
  assign out_valid = (state == STREAM);
  assign out_idx   = idx;
  assign out_last  = (state == STREAM) && (idx == IDX_W'(NUM_ELEM-1));
  assign busy      = |bank_full;

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    rd_ptr_nxt = rd_ptr;
    rel_bank   = 1'b0;
    load_data  = 1'b0;
    case (state)
      IDLE: begin
        if (bank_full[rd_ptr]) begin
          state_nxt = STREAM;
          idx_nxt   = '0;
          load_data = 1'b1;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (idx == IDX_W'(NUM_ELEM-1)) begin
            rel_bank   = 1'b1;
            rd_ptr_nxt = ~rd_ptr;
            idx_nxt    = '0;
            // Chain straight into the other bank when it already holds a window.
            if (bank_full[~rd_ptr]) begin
              load_data = 1'b1;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            idx_nxt   = idx + 1'b1;
            load_data = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A bank emptied by this cycle's last beat counts as free for a same-cycle capture.
    wr_free  = ~bank_full[wr_ptr] | (rel_bank & (rd_ptr == wr_ptr));
    do_write = cap & wr_free;
    do_drop  = cap & ~wr_free;

    bank_full_nxt = bank_full;
    if (rel_bank) bank_full_nxt[rd_ptr] = 1'b0;
    if (do_write) bank_full_nxt[wr_ptr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cap_sr    <= '0;
      bank_full <= '0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      idx       <= '0;
      out_data  <= '0;
      overflow  <= 1'b0;
    end else begin
      for (int i = CAPTURE_DLY-1; i > 0; i--) cap_sr[i] <= cap_sr[i-1];
      cap_sr[0] <= rollover & enable;
      state     <= state_nxt;
      bank_full <= bank_full_nxt;
      rd_ptr    <= rd_ptr_nxt;
      idx       <= idx_nxt;
      if (do_write) wr_ptr <= ~wr_ptr;
      if (load_data) out_data <= mem[rd_ptr_nxt][idx_nxt];
      if (do_drop) overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < NUM_ELEM; i++) mem[wr_ptr][i] <= acc_in[i*ACC_WIDTH +: ACC_WIDTH];
    end
  end

endmodule

// File: tb/tb_simd_result_drain.sv
// Bench for simd_result_drain: window-level reference model with a beat scoreboard.
module tb_simd_result_drain;
  localparam int N  = 16;
  localparam int W  = 24;
  localparam int D  = 2;
  localparam int IW = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic             rollover = 1'b0;
  logic             out_ready = 1'b0;
  logic             clr_ovf = 1'b0;
  logic [N*W-1:0]   acc_in = '0;
  logic             out_valid, out_last, busy, overflow;
  logic [W-1:0]     out_data;
  logic [IW-1:0]    out_idx;

  int pass_cnt = 0;
  int total = 0;

  always #5 clk = ~clk;

  simd_result_drain #(.NUM_ELEM(N), .ACC_WIDTH(W), .CAPTURE_DLY(D), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rollover(rollover), .acc_in(acc_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .busy(busy), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  // Reference model: windows held (0..2), pending captures by due edge, expected beats.
  logic [W+IW:0] exp_q[$];
  logic [W+IW:0] obs_q[$];
  int            due_q[$];
  int            cyc = 0;
  int            held = 0;
  int            beats = 0;
  bit            m_ovf = 1'b0;
  int            stall_err = 0;
  bit            prev_stall = 1'b0;
  logic [W+IW:0] prev_beat;
  logic [W+IW:0] m_cur;
  bit            m_cap;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      due_q.delete();
      held = 0;
      beats = 0;
      m_ovf = 1'b0;
      prev_stall = 1'b0;
    end else begin
      m_cur = {out_last, out_idx, out_data};
      if (prev_stall && (!out_valid || m_cur !== prev_beat)) stall_err++;
      prev_stall = out_valid && !out_ready;
      prev_beat = m_cur;
      if (out_valid && out_ready) begin
        obs_q.push_back(m_cur);
        beats++;
        if (beats == N) begin
          beats = 0;
          held--;
        end
      end
      if (clr_ovf) m_ovf = 1'b0;
      m_cap = (due_q.size() > 0) && (due_q[0] == cyc + 1);
      if (m_cap) begin
        void'(due_q.pop_front());
        if (held < 2) begin
          held++;
          for (int i = 0; i < N; i++) exp_q.push_back({(i == N-1), IW'(i), acc_in[i*W +: W]});
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (rollover && enable) due_q.push_back(cyc + 1 + D);
    end
    cyc++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic roll();
    rollover = 1'b1;
    tick(1);
    rollover = 1'b0;
  endtask

  task automatic rand_pat(output logic [N*W-1:0] p);
    for (int i = 0; i < N; i++) p[i*W +: W] = W'($urandom());
  endtask

  task automatic begin_scn();
    obs_q.delete();
    exp_q.delete();
    stall_err = 0;
  endtask

  task automatic wait_idle(input int budget, output bit timed_out);
    int n = 0;
    tick(D + 2);
    while ((busy || out_valid) && n < budget) begin
      tick(1);
      n++;
    end
    timed_out = busy || out_valid;
  endtask

  function automatic int stream_diff();
    if (obs_q.size() != exp_q.size()) return -2;
    foreach (obs_q[i]) if (obs_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    #1;
    total++;
    if ({out_valid, out_last, busy, overflow, out_data, out_idx} !== '0) begin
      $display("FAIL reset_outputs: got %h, want 0", {out_valid, out_last, busy, overflow, out_data, out_idx});
    end else pass_cnt++;
    tick(2);
    rst_n = 1'b1;
    enable = 1'b1;
    tick(2);
    total++;
    if ({out_valid, busy, overflow} !== 3'b000) begin
      $display("FAIL reset_release: valid/busy/ovf=%b, want 000", {out_valid, busy, overflow});
    end else pass_cnt++;
  endtask

  task automatic test_single();
    bit to;
    int d;
    begin_scn();
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) acc_in[i*W +: W] = W'(i + 100);
    roll();
    tick(D);
    total++;
    if (out_valid !== 1'b0) $display("FAIL single_early_valid: got %b, want 0", out_valid);
    else pass_cnt++;
    tick(1);
    total++;
    if ({out_valid, out_idx, out_data} !== {1'b1, 4'd0, 24'd100}) begin
      $display("FAIL single_first_beat: got v=%b idx=%0d data=%0d, want v=1 idx=0 data=100", out_valid, out_idx, out_data);
    end else pass_cnt++;
    wait_idle(100, to);
    total++;
    if (to) $display("FAIL single_drain_timeout: busy=%b valid=%b, want 0 0", busy, out_valid);
    else pass_cnt++;
    d = stream_diff();
    total++;
    if (d != -1) $display("FAIL single_stream: obs %0d beats exp %0d beats, first diff %0d", obs_q.size(), exp_q.size(), d);
    else pass_cnt++;
    total++;
    if (obs_q.size() != N || obs_q[N-1] !== {1'b1, 4'd15, 24'd115}) begin
      $display("FAIL single_last_beat: got %0d beats, want 16 ending {last=1,idx=15,data=115}", obs_q.size());
    end else pass_cnt++;
    total++;
    if ({busy, overflow} !== 2'b00) $display("FAIL single_busy_after: busy/ovf=%b, want 00", {busy, overflow});
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [N*W-1:0] p;
    logic [3:0] pat = 4'b1001;
    int k = 0;
    int d;
    begin_scn();
    rand_pat(p);
    acc_in = p;
    out_ready = 1'b1;
    roll();
    tick(D + 1);
    while ((busy || out_valid) && k < 200) begin
      out_ready = pat[k % 4];
      tick(1);
      k++;
    end
    out_ready = 1'b1;
    total++;
    if (busy || out_valid) $display("FAIL bp_drain_timeout: busy=%b valid=%b, want 0 0", busy, out_valid);
    else pass_cnt++;
    total++;
    if (stall_err != 0) $display("FAIL bp_stall_stable: %0d unstable stalls, want 0", stall_err);
    else pass_cnt++;
    d = stream_diff();
    total++;
    if (d != -1 || obs_q.size() != N) begin
      $display("FAIL bp_stream: obs %0d beats exp %0d beats, first diff %0d", obs_q.size(), exp_q.size(), d);
    end else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [N*W-1:0] a, b;
    bit to;
    int d;
    begin_scn();
    rand_pat(a);
    rand_pat(b);
    out_ready = 1'b1;
    acc_in = a;
    roll();
    tick(D);
    acc_in = b;
    tick(19 - D);
    roll();
    wait_idle(100, to);
    d = stream_diff();
    total++;
    if (to || d != -1 || obs_q.size() != 2*N) begin
      $display("FAIL b2b_stream: obs %0d beats exp %0d beats, first diff %0d, timeout %0b", obs_q.size(), exp_q.size(), d, to);
    end else pass_cnt++;
    total++;
    if (overflow !== 1'b0) $display("FAIL b2b_overflow: got %b, want 0", overflow);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [N*W-1:0] a, b, c;
    bit to;
    int d;
    begin_scn();
    rand_pat(a);
    rand_pat(b);
    rand_pat(c);
    out_ready = 1'b0;
    acc_in = a;
    roll();
    tick(D);
    acc_in = b;
    tick(19 - D);
    roll();
    tick(D);
    acc_in = c;
    tick(19 - D);
    roll();
    tick(D + 2);
    total++;
    if ({overflow, busy} !== 2'b11) $display("FAIL ovf_set: ovf/busy=%b, want 11", {overflow, busy});
    else pass_cnt++;
    out_ready = 1'b1;
    wait_idle(100, to);
    d = stream_diff();
    total++;
    if (to || d != -1 || obs_q.size() != 2*N || stall_err != 0) begin
      $display("FAIL ovf_stream: obs %0d beats exp %0d (want 32), diff %0d, stalls %0d", obs_q.size(), exp_q.size(), d, stall_err);
    end else pass_cnt++;
    total++;
    if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b, want 1", overflow);
    else pass_cnt++;
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    total++;
    if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b, want 0", overflow);
    else pass_cnt++;
  endtask

  task automatic test_collision();
    logic [N*W-1:0] a, b, c;
    bit to;
    int d;
    begin_scn();
    rand_pat(a);
    rand_pat(b);
    rand_pat(c);
    out_ready = 1'b1;
    // Third capture lands on the edge that accepts the first window's last beat.
    for (int t = 0; t <= 17 + D; t++) begin
      rollover = (t == 0) || (t == 5) || (t == 17);
      acc_in = (t <= D) ? a : ((t <= 5 + D) ? b : c);
      tick(1);
    end
    rollover = 1'b0;
    wait_idle(150, to);
    total++;
    if (overflow !== 1'b0) $display("FAIL coll_overflow: got %b, want 0", overflow);
    else pass_cnt++;
    d = stream_diff();
    total++;
    if (to || d != -1 || obs_q.size() != 3*N) begin
      $display("FAIL coll_stream: obs %0d beats exp %0d (want 48), diff %0d, timeout %0b", obs_q.size(), exp_q.size(), d, to);
    end else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [N*W-1:0] p;
    bit to;
    int n = 0;
    int d;
    begin_scn();
    rand_pat(p);
    acc_in = p;
    out_ready = 1'b1;
    roll();
    while (!(out_valid && out_idx == 4'd7) && n < 50) begin
      tick(1);
      n++;
    end
    total++;
    if (!(out_valid && out_idx == 4'd7)) $display("FAIL rst_reach_beat7: idx=%0d valid=%b", out_idx, out_valid);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, busy} !== 2'b00) $display("FAIL rst_mid_outputs: valid/busy=%b, want 00", {out_valid, busy});
    else pass_cnt++;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    begin_scn();
    rand_pat(p);
    acc_in = p;
    roll();
    wait_idle(100, to);
    d = stream_diff();
    total++;
    if (to || d != -1 || obs_q.size() != N) begin
      $display("FAIL rst_clean_window: obs %0d beats exp %0d, diff %0d, timeout %0b", obs_q.size(), exp_q.size(), d, to);
    end else pass_cnt++;
    total++;
    if (obs_q.size() == 0 || obs_q[0][W+IW-1:W] !== 4'd0) $display("FAIL rst_first_idx: beats=%0d, want first idx 0", obs_q.size());
    else pass_cnt++;
  endtask

  task automatic test_enable_off();
    logic [N*W-1:0] p;
    int seen = 0;
    begin_scn();
    rand_pat(p);
    acc_in = p;
    out_ready = 1'b1;
    enable = 1'b0;
    roll();
    for (int i = 0; i < D + 6; i++) begin
      if (out_valid || busy) seen++;
      tick(1);
    end
    enable = 1'b1;
    total++;
    if (seen != 0 || obs_q.size() != 0) $display("FAIL enable_off: %0d active cycles, %0d beats, want 0 0", seen, obs_q.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_collision();
    test_reset_mid();
    test_enable_off();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
